// File: rtl/nv_ram_rws_64x116_fifo_ctrl_pkg.sv
// rtl/nv_ram_rws_64x116_fifo_ctrl_pkg.sv - shared geometry for the 64x116 RAM-backed FIFO controller
package nv_ram_rws_64x116_fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 64;
    localparam int FIFO_AW    = 6;
    localparam int FIFO_DW    = 116;
    localparam int FIFO_PTR_W = FIFO_AW + 1;

endpackage

// File: rtl/nv_fifo_ptr_cnt.sv
// rtl/nv_fifo_ptr_cnt.sv - AW+1 bit wrapping FIFO pointer with increment enable
module nv_fifo_ptr_cnt
    import nv_ram_rws_64x116_fifo_ctrl_pkg::*;
#(
    parameter int AW = FIFO_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [AW:0] ptr
);

    logic [AW:0] ptr_q;
    logic [AW:0] ptr_d;

    // The extra MSB is the wrap bit that tells full from empty.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/nv_ram_rws_64x116_fifo_ctrl.sv
// rtl/nv_ram_rws_64x116_fifo_ctrl.sv - valid/ready FIFO sequencer around a registered-read-address 64x116 RAM
module nv_ram_rws_64x116_fifo_ctrl
    import nv_ram_rws_64x116_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   wr_count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] iss_ptr;
    logic [AW:0] pend;
    logic [AW:0] count_q;
    logic [AW:0] count_d;
    logic        out_vld_q;
    logic        out_vld_d;
    logic        push;
    logic        pop;
    logic        issue;

    nv_fifo_ptr_cnt #(.AW(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    nv_fifo_ptr_cnt #(.AW(AW)) u_iss_ptr (
        .clk (clk),
        .rst (rst),
        .inc (issue),
        .ptr (iss_ptr)
    );

    // The output stage's word lives in its RAM slot; re-issuing only when the
    // stage drains keeps the latched read address, and so rd_pd, stable.
    always_comb begin
        wr_prdy   = !rst && (count_q != DEPTH_C);
        push      = wr_pvld && wr_prdy;
        pend      = wr_ptr - iss_ptr;
        issue     = !rst && (pend != '0) && (!out_vld_q || rd_prdy);
        rd_pvld   = !rst && out_vld_q;
        pop       = rd_pvld && rd_prdy;
        out_vld_d = issue || (out_vld_q && !rd_prdy);
        count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign ram_we   = push;
    assign ram_wa   = wr_ptr[AW-1:0];
    assign ram_di   = wr_pd;
    assign ram_re   = issue;
    assign ram_ra   = iss_ptr[AW-1:0];
    assign rd_pd    = ram_dout;
    assign wr_count = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == DEPTH_C)));
    a_no_re_stall: assert property (@(posedge clk) disable iff (rst)
        !(ram_re && out_vld_q && !rd_prdy));
    a_count_consistent: assert property (@(posedge clk) disable iff (rst)
        count_q == (pend + {{AW{1'b0}}, out_vld_q}));

endmodule

// File: tb/tb_nv_ram_rws_64x116_fifo_ctrl.sv
// tb/tb_nv_ram_rws_64x116_fifo_ctrl.sv - self-checking bench for the RAM-backed FIFO controller
module tb_nv_ram_rws_64x116_fifo_ctrl;
    import nv_ram_rws_64x116_fifo_ctrl_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;
    localparam int AW    = FIFO_AW;
    localparam int DW    = FIFO_DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   wr_count;

    always #5 clk = ~clk;

    nv_ram_rws_64x116_fifo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr_pvld  (wr_pvld),
        .wr_prdy  (wr_prdy),
        .wr_pd    (wr_pd),
        .rd_pvld  (rd_pvld),
        .rd_prdy  (rd_prdy),
        .rd_pd    (rd_pd),
        .ram_wa   (ram_wa),
        .ram_we   (ram_we),
        .ram_di   (ram_di),
        .ram_ra   (ram_ra),
        .ram_re   (ram_re),
        .ram_dout (ram_dout),
        .wr_count (wr_count)
    );

    // RAM with registered read address, combinational data out
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_lat;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_lat <= ram_ra;
    end
    assign ram_dout = mem[ra_lat];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: the FIFO as an ordered queue plus "head is on the output"
    logic [DW-1:0] q[$];
    bit            m_vld;
    int            wr_n, iss_n;
    bit            prev_stall;
    logic [DW-1:0] prev_pd;
    logic [DW-1:0] got[$];
    int            pop_cyc[$];
    int            cyc = 0;
    int            wraps = 0;

    task automatic step(input bit r, input bit wv, input logic [DW-1:0] wd, input bit rr);
        bit e_prdy, e_push, e_iss, e_vld, e_pop;
        int pend;
        rst = r; wr_pvld = wv; wr_pd = wd; rd_prdy = rr;
        @(negedge clk);
        e_prdy = !r && (q.size() != DEPTH);
        e_push = wv && e_prdy;
        pend   = q.size() - int'(m_vld);
        e_iss  = !r && (pend > 0) && (!m_vld || rr);
        e_vld  = !r && m_vld;
        e_pop  = e_vld && rr;
        chk("wr_prdy", 128'(wr_prdy), 128'(e_prdy));
        chk("ram_we", 128'(ram_we), 128'(e_push));
        chk("ram_re", 128'(ram_re), 128'(e_iss));
        chk("rd_pvld", 128'(rd_pvld), 128'(e_vld));
        if (!r) chk("wr_count", 128'(wr_count), 128'(q.size()));
        if (e_vld) chk("rd_pd", 128'(rd_pd), 128'(q[0]));
        if (e_push) begin
            chk("ram_wa", 128'(ram_wa), 128'(wr_n % DEPTH));
            chk("ram_di", 128'(ram_di), 128'(wd));
            if (ram_wa == '0) wraps++;
        end
        if (e_iss) chk("ram_ra", 128'(ram_ra), 128'(iss_n % DEPTH));
        if (prev_stall && e_vld) chk("stall_hold", 128'(rd_pd), 128'(prev_pd));
        prev_stall = e_vld && !rr;
        prev_pd    = rd_pd;
        @(posedge clk);
        if (r) begin
            q.delete(); m_vld = 0; wr_n = 0; iss_n = 0; prev_stall = 0;
        end else begin
            if (e_pop) begin
                got.push_back(q[0]); pop_cyc.push_back(cyc); void'(q.pop_front());
            end
            if (e_push) begin q.push_back(wd); wr_n++; end
            if (e_iss) iss_n++;
            m_vld = e_iss || (m_vld && !rr);
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        bit            wv;
        logic [DW-1:0] wd;
        bit            rr;
        bit            e_prdy, e_we, e_re, e_vld;
        logic [AW-1:0] e_wa, e_ra;
        logic [DW-1:0] e_pd;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [127:0] rnd;
        vt[0] = '{1, DW'(1), 1, 1, 1, 0, 0, 6'd0, 6'd0, DW'(0), 7'd0};
        vt[1] = '{0, DW'(0), 1, 1, 0, 1, 0, 6'd0, 6'd0, DW'(0), 7'd1};
        vt[2] = '{0, DW'(0), 1, 1, 0, 0, 1, 6'd0, 6'd0, DW'(1), 7'd1};
        vt[3] = '{0, DW'(0), 1, 1, 0, 0, 0, 6'd0, 6'd0, DW'(0), 7'd0};

        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        chk("rst_count", 128'(wr_count), 128'(0));
        chk("rst_pvld", 128'(rd_pvld), 128'(0));

        // Single word latency: we at 0, re at 1, data at 2
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            wr_pvld = vt[i].wv; wr_pd = vt[i].wd; rd_prdy = vt[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d_prdy", i), 128'(wr_prdy), 128'(vt[i].e_prdy));
            chk($sformatf("v%0d_we", i), 128'(ram_we), 128'(vt[i].e_we));
            chk($sformatf("v%0d_re", i), 128'(ram_re), 128'(vt[i].e_re));
            chk($sformatf("v%0d_pvld", i), 128'(rd_pvld), 128'(vt[i].e_vld));
            chk($sformatf("v%0d_cnt", i), 128'(wr_count), 128'(vt[i].e_cnt));
            if (vt[i].e_we) chk($sformatf("v%0d_wa", i), 128'(ram_wa), 128'(vt[i].e_wa));
            if (vt[i].e_re) chk($sformatf("v%0d_ra", i), 128'(ram_ra), 128'(vt[i].e_ra));
            if (vt[i].e_vld) chk($sformatf("v%0d_pd", i), 128'(rd_pd), 128'(vt[i].e_pd));
            @(posedge clk); cyc++; #1;
        end
        wr_n = 1; iss_n = 1;

        // Fill to full with the consumer stalled
        for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(i + 100), 0);
        chk("full_count", 128'(wr_count), 128'(DEPTH));
        chk("full_prdy", 128'(wr_prdy), 128'(0));
        step(0, 1, DW'(999), 0);
        step(0, 1, DW'(999), 1);
        chk("prdy_after_pop", 128'(wr_prdy), 128'(1));
        for (int i = 0; i < 12; i++) begin
            step(0, 1, DW'(500 + i), 1);
            chk("near_full_cnt", 128'((wr_count == 7'd63) || (wr_count == 7'd64)), 128'(1));
        end
        repeat (DEPTH + 8) step(0, 0, '0, 1);
        chk("drain1_empty", 128'(wr_count), 128'(0));

        // Streaming 200 words, one per cycle
        got.delete(); pop_cyc.delete(); wraps = 0;
        for (int i = 0; i < 200; i++) step(0, 1, DW'(i), 1);
        repeat (4) step(0, 0, '0, 1);
        chk("stream_n", 128'(got.size()), 128'(200));
        for (int i = 0; i < 200 && i < got.size(); i++)
            if (got[i] !== DW'(i)) chk($sformatf("stream_%0d", i), 128'(got[i]), 128'(i));
        if (pop_cyc.size() == 200)
            chk("stream_rate", 128'(pop_cyc[199] - pop_cyc[0]), 128'(199));
        chk("wraps_ge3", 128'(wraps >= 3), 128'(1));

        // Random push/stall traffic
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step(0, ($urandom_range(0, 9) < 7), rnd[DW-1:0], $urandom_range(0, 1) == 1);
        end
        repeat (DEPTH + 8) step(0, 0, '0, 1);
        chk("rand_drain", 128'(wr_count), 128'(0));

        // Reset with 10 entries held and the output stage loaded
        for (int i = 0; i < 10; i++) step(0, 1, DW'(i + 7), 0);
        step(0, 0, '0, 0);
        chk("pre_rst_pvld", 128'(rd_pvld), 128'(1));
        step(1, 0, '0, 0);
        chk("post_rst_pvld", 128'(rd_pvld), 128'(0));
        chk("post_rst_cnt", 128'(wr_count), 128'(0));
        got.delete();
        step(0, 1, DW'(12'hABC), 1);
        repeat (4) step(0, 0, '0, 1);
        chk("rst_only_one", 128'(got.size()), 128'(1));
        if (got.size() > 0) chk("rst_first_pd", 128'(got[0]), 128'(12'hABC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
